// File: rtl/ahb3lite_rx_buffer.sv
// Receive-side buffer behind the AHB-Lite read master: collects read words into a show-ahead FIFO and tags them for the consumer.
// Latency: a word strobed at edge t is presented on o_Data after edge t; completion pulse follows the final pop by one cycle.
// Backpressure: consumer stalls via i_Data_Ready; strobes arriving while the FIFO is full with no pop are dropped and flagged sticky.
module ahb3lite_rx_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          HCLK,
    input  logic          HRESET,
    input  logic          i_Start,
    input  logic [5:0]    i_BUFFER_LENGTH,
    input  logic [31:0]   i_HRDATA,
    input  logic          i_HRDATA_En,
    input  logic          i_Master_Done,
    output logic [31:0]   o_Data,
    output logic          o_Data_Valid,
    input  logic          i_Data_Ready,
    output logic [3:0]    o_Byte_En,
    output logic          o_Last,
    output logic [AW:0]   o_Count,
    output logic          o_Busy,
    output logic          o_Overflow,
    output logic          o_Done
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DRAIN   = 2'd2
    } state_t;

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

    state_t         state_q, state_d;

    logic [5:0]     len_q;
    logic [4:0]     nwords_q;
    logic [4:0]     rcv_cnt_q;
    logic [4:0]     out_cnt_q;
    logic           short_q;
    logic           ovf_q;
    logic           zdone_q;

    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [AW:0]    count_q;
    logic [31:0]    mem [DEPTH];

    logic [6:0]     len_p3;
    logic [4:0]     nwords_calc;
    logic [4:0]     rcv_cnt_inc;
    logic           start_acc;
    logic           fifo_empty;
    logic           fifo_full;
    logic           pop;
    logic           push_req;
    logic           push_ok;
    logic           push_drop;
    logic           reach_n;
    logic           drain_done;
    logic           last_w;

    // Word count of the new command: ceil(L/4), 0..16.
    assign len_p3      = {1'b0, i_BUFFER_LENGTH} + 7'd3;
    assign nwords_calc = len_p3[6:2];

    assign start_acc   = (state_q == S_IDLE) && i_Start;
    assign fifo_empty  = (count_q == '0);
    assign fifo_full   = (count_q == FULL_CNT);
    assign pop         = !fifo_empty && i_Data_Ready;

    // Strobes only count while collecting and before the word budget is met.
    assign push_req    = (state_q == S_COLLECT) && i_HRDATA_En && (rcv_cnt_q != nwords_q);
    assign push_ok     = push_req && (!fifo_full || pop);
    assign push_drop   = push_req && fifo_full && !pop;
    assign rcv_cnt_inc = rcv_cnt_q + 5'd1;
    assign reach_n     = push_ok && (rcv_cnt_inc == nwords_q);

    assign drain_done  = (state_q == S_DRAIN) && fifo_empty;

    // Next-state selection for the transfer sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_acc && (i_BUFFER_LENGTH != 6'd0)) begin
                    state_d = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (reach_n || i_Master_Done) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (fifo_empty) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Command latch and transfer bookkeeping (length, received/popped counts, short-end flag).
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            len_q     <= '0;
            nwords_q  <= '0;
            rcv_cnt_q <= '0;
            out_cnt_q <= '0;
            short_q   <= 1'b0;
            zdone_q   <= 1'b0;
        end else begin
            zdone_q <= start_acc && (i_BUFFER_LENGTH == 6'd0);
            if (start_acc) begin
                len_q     <= i_BUFFER_LENGTH;
                nwords_q  <= nwords_calc;
                rcv_cnt_q <= '0;
                out_cnt_q <= '0;
                short_q   <= 1'b0;
            end else begin
                if (push_ok) begin
                    rcv_cnt_q <= rcv_cnt_inc;
                end
                if (pop) begin
                    out_cnt_q <= out_cnt_q + 5'd1;
                end
                // Master ended early: the last buffered word becomes the final one.
                if ((state_q == S_COLLECT) && i_Master_Done && !reach_n) begin
                    short_q <= 1'b1;
                end
            end
        end
    end

    // Sticky overflow: cleared only by reset or the next accepted command.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            ovf_q <= 1'b0;
        end else if (start_acc) begin
            ovf_q <= 1'b0;
        end else if (push_drop) begin
            ovf_q <= 1'b1;
        end
    end

    // FIFO pointers and occupancy; reset flushes by clearing these.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + ONE_CNT;
                2'b01:   count_q <= count_q - ONE_CNT;
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge HCLK) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= i_HRDATA;
        end
    end

    // Final-word detection: either the Nth word, or the last word left after an early master finish.
    assign last_w = !fifo_empty &&
                    ((out_cnt_q == (nwords_q - 5'd1)) ||
                     (short_q && (count_q == ONE_CNT)));

    // Output tagging: head word, lane enables for a partial final word.
    always_comb begin
        o_Data    = '0;
        o_Byte_En = 4'h0;
        if (!fifo_empty) begin
            o_Data    = mem[rd_ptr_q];
            o_Byte_En = 4'hF;
            if (last_w) begin
                case (len_q[1:0])
                    2'b01:   o_Byte_En = 4'b0001;
                    2'b10:   o_Byte_En = 4'b0011;
                    2'b11:   o_Byte_En = 4'b0111;
                    default: o_Byte_En = 4'hF;
                endcase
            end
        end
    end

    assign o_Data_Valid = !fifo_empty;
    assign o_Last       = last_w;
    assign o_Count      = count_q;
    assign o_Busy       = (state_q != S_IDLE);
    assign o_Overflow   = ovf_q;
    assign o_Done       = zdone_q || drain_done;

endmodule
